// File: rtl/io_uart_tx_pkg.sv
// io_uart_tx_pkg: register offsets and FSM state encodings shared by the UART transmitter
package io_uart_tx_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// io_uart_tx_sync_fifo: synchronous FIFO; a push while full is taken only if a pop frees a slot the same cycle
module io_uart_tx_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == DEPTH;
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!resetb) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status, divisor and control registers
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR   = 4'h0,
  parameter int          FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        tx,
  output logic        irq
);
  logic sel, wr, push, pop, full, empty, busy, ovf, tx_en, irq_en;
  logic [1:0] rsel, state;
  logic [FIFO_AW:0] count;
  logic [7:0] dout, sh;
  logic [15:0] div, cnt;
  logic [2:0] bit_idx;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = &{1'b0, io_addr[1:0], io_data_write[31:16]};
  assign sel = io_en && io_addr[7:4] == BASE_ADDR;
  assign rsel = io_addr[3:2];
  assign wr = sel && io_we;
  assign push = wr && rsel == REG_TXDATA;
  assign busy = state != S_IDLE;
  assign pop = !busy && tx_en && !empty;
  assign irq = irq_en && empty && !busy;
  assign status = 32'({count, ovf, busy, empty, full});
  assign io_data_read = !sel ? '0
                      : rsel == REG_STATUS ? status
                      : rsel == REG_BAUDDIV ? {16'b0, div}
                      : rsel == REG_CTRL ? {30'b0, irq_en, tx_en}
                      : '0;
  io_uart_tx_sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .resetb(resetb), .push(push), .pop(pop), .din(io_data_write[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  // every bit reloads from the live divisor, so a mid-frame BAUDDIV write applies from the next bit
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= S_IDLE;
      tx <= 1'b1;
      cnt <= '0;
      sh <= '0;
      bit_idx <= '0;
      div <= DEFAULT_DIV;
      tx_en <= 1'b1;
      irq_en <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (wr && rsel == REG_BAUDDIV) div <= io_data_write[15:0] == '0 ? 16'd1 : io_data_write[15:0];
      if (wr && rsel == REG_CTRL) {irq_en, tx_en} <= io_data_write[1:0];
      if (push && full && !pop) ovf <= 1'b1;
      else if (wr && rsel == REG_STATUS && io_data_write[3]) ovf <= 1'b0;
      if (pop) begin
        sh <= dout;
        cnt <= div - 16'd1;
        tx <= 1'b0;
        state <= S_START;
      end else if (busy) begin
        if (cnt != '0) cnt <= cnt - 16'd1;
        else begin
          cnt <= div - 16'd1;
          if (state == S_START) begin
            tx <= sh[0];
            bit_idx <= '0;
            state <= S_DATA;
          end else if (state == S_DATA) begin
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
              state <= S_STOP;
            end else begin
              sh <= sh >> 1;
              tx <= sh[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else state <= S_IDLE;
        end
      end
    end
  end
endmodule
